rv_mem_arbiter: RTL
===================

RV_MEM_ARBITER -- requirements
Module: rv_mem_arbiter

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 if_req  input  1  fetch-stage read request; held with if_addr stable until if_valid.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_rdata  output  32  fetched instruction; meaningful only while if_valid=1.
REQ-007 if_valid  output  1  one-cycle fetch completion pulse.
REQ-008 dm_req  input  1  memory-stage request; held with dm_* stable until dm_valid.
REQ-009 dm_we  input  1  1=store, 0=load.
REQ-010 dm_be  input  4  store byte enables.
REQ-011 dm_addr  input  32  data address.
REQ-012 dm_wdata  input  32  store data.
REQ-013 dm_rdata  output  32  load data; meaningful only while dm_valid=1.
REQ-014 dm_valid  output  1  one-cycle data completion pulse (loads and stores).
REQ-015 br_taken  input  1  branch redirect; cancels any in-progress fetch.
REQ-016 mem_req  output  1  shared memory port command valid.
REQ-017 mem_we, mem_be[3:0], mem_addr[31:0], mem_wdata[31:0]  output  latched command fields.
REQ-018 mem_gnt  input  1  port accepts command in the cycle mem_req=1 and mem_gnt=1.
REQ-019 mem_rvalid  input  1  response (read data or write ack), earliest one cycle after gnt.
REQ-020 mem_rdata  input  32  response read data.
REQ-021 stall_if  output  1  fetch-stage stall to hazard logic.
REQ-022 stall_mem  output  1  memory-stage stall to hazard logic.

Function
REQ-023 FSM states SHALL be IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D, DROP_I; at most one transaction outstanding.
REQ-024 IDLE: only dm_req -> latch dm_* into command regs, go REQ_D; only if_req (and br_taken=0) -> latch if_addr with we=0/be=4'hF/wdata=0, go REQ_I.
REQ-025 IDLE with both requests: grant the requester not granted last (1-bit last_gnt, updated on each latch); if fetch would win but br_taken=1, grant data.
REQ-026 IDLE with if_req and br_taken=1 and no dm_req: stay IDLE, issue nothing.
REQ-027 REQ_x: mem_req=1 with latched fields stable; mem_gnt=1 -> WAIT_x; otherwise hold.
REQ-028 REQ_I with br_taken=1 and mem_gnt=0: deassert mem_req next cycle, return IDLE, no if_valid.
REQ-029 REQ_I with br_taken=1 and mem_gnt=1 in same cycle: go DROP_I (command already accepted).
REQ-030 WAIT_I with br_taken=1 and mem_rvalid=0: go DROP_I; with mem_rvalid=1 same cycle: suppress if_valid, go IDLE.
REQ-031 WAIT_I/WAIT_D: mem_rvalid=1 -> combinationally pulse if_valid/dm_valid, pass mem_rdata to if_rdata/dm_rdata, go IDLE.
REQ-032 DROP_I: swallow next mem_rvalid, no if_valid, then IDLE.
REQ-033 mem_rvalid outside WAIT_x/DROP_I SHALL be ignored; br_taken never affects data transactions.
REQ-034 stall_if = if_req & ~if_valid; stall_mem = dm_req & ~dm_valid (combinational).
REQ-035 Minimum latency: request seen in cycle N, gnt in N+1, rvalid in N+2 -> valid in N+2.
REQ-036 mem_req SHALL be driven only from registered state; no combinational path from *_req to mem_req.

Reset
REQ-037 rst_n=0 SHALL immediately force state=IDLE, mem_req=0, command regs=0, last_gnt=data (fetch wins first tie), if_valid=dm_valid=0.
REQ-038 Reset during REQ_x/WAIT_x SHALL abandon the transaction; a later stray mem_rvalid is ignored per REQ-033.

Verification
V1 if_req=1 addr=0x100 only, gnt immediate, rvalid next -> mem_req in cycle 1, if_valid cycle 2 with if_rdata=mem_rdata, stall_if 1 in cycles 0-1.
V2 if_req and dm_req together from reset -> fetch granted first, then load; next simultaneous pair -> data first (alternation).
V3 store dm_we=1 be=4'b0011 wdata=0xDEADBEEF, gnt held low 3 cycles -> mem_* stable all 4 cycles, dm_valid on rvalid.
V4 fetch in WAIT_I, br_taken pulse, rvalid 2 cycles later -> no if_valid, state IDLE after rvalid, pending dm_req then granted.
V5 fetch in REQ_I, br_taken with gnt=0 -> mem_req drops next cycle, no response expected.
V6 rst_n asserted in WAIT_D -> outputs zero immediately; stray rvalid after release produces no valid.

Source files
------------

// File: rtl/rv_mem_arbiter.sv
// Arbitrates the fetch and data stages onto one shared memory port.
// At most one transaction is in flight; branch redirects can cancel a fetch.
module rv_mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_be_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_valid_o,
    input  logic        br_taken_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_if_o,
    output logic        stall_mem_o
);

    typedef enum logic [2:0] {
        StIdle,
        StReqI,
        StReqD,
        StWaitI,
        StWaitD,
        StDropI
    } state_e;

    localparam logic GntFetch = 1'b0;
    localparam logic GntData  = 1'b1;

    state_e      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;
    logic        cmd_we_q, cmd_we_d;
    logic [3:0]  cmd_be_q, cmd_be_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;
    logic        grant_fetch, grant_data;

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        cmd_we_d    = cmd_we_q;
        cmd_be_d    = cmd_be_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        if_valid_o  = 1'b0;
        dm_valid_o  = 1'b0;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;

        case (state_q)
            StIdle: begin
                // On a tie fetch wins only if data went last and no redirect is pending.
                if (if_req_i && dm_req_i) begin
                    if (last_gnt_q == GntData && !br_taken_i) grant_fetch = 1'b1;
                    else                                      grant_data  = 1'b1;
                end else if (dm_req_i) begin
                    grant_data = 1'b1;
                end else if (if_req_i && !br_taken_i) begin
                    grant_fetch = 1'b1;
                end
            end
            StReqI: begin
                if (br_taken_i) state_d = mem_gnt_i ? StDropI : StIdle;
                else if (mem_gnt_i) state_d = StWaitI;
            end
            StReqD: begin
                if (mem_gnt_i) state_d = StWaitD;
            end
            StWaitI: begin
                if (mem_rvalid_i) begin
                    if_valid_o = ~br_taken_i;
                    state_d    = StIdle;
                end else if (br_taken_i) begin
                    state_d = StDropI;
                end
            end
            StWaitD: begin
                if (mem_rvalid_i) begin
                    dm_valid_o = 1'b1;
                    state_d    = StIdle;
                end
            end
            StDropI: begin
                if (mem_rvalid_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (grant_data) begin
            state_d     = StReqD;
            last_gnt_d  = GntData;
            cmd_we_d    = dm_we_i;
            cmd_be_d    = dm_be_i;
            cmd_addr_d  = dm_addr_i;
            cmd_wdata_d = dm_wdata_i;
        end else if (grant_fetch) begin
            state_d     = StReqI;
            last_gnt_d  = GntFetch;
            cmd_we_d    = 1'b0;
            cmd_be_d    = 4'hF;
            cmd_addr_d  = if_addr_i;
            cmd_wdata_d = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_gnt_q  <= GntData;
            cmd_we_q    <= 1'b0;
            cmd_be_q    <= 4'h0;
            cmd_addr_q  <= 32'h0;
            cmd_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            cmd_we_q    <= cmd_we_d;
            cmd_be_q    <= cmd_be_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
        end
    end

    // Request comes purely from state so no *_req input reaches mem_req combinationally.
    assign mem_req_o   = (state_q == StReqI) || (state_q == StReqD);
    assign mem_we_o    = cmd_we_q;
    assign mem_be_o    = cmd_be_q;
    assign mem_addr_o  = cmd_addr_q;
    assign mem_wdata_o = cmd_wdata_q;

    assign if_rdata_o  = if_valid_o ? mem_rdata_i : 32'h0;
    assign dm_rdata_o  = dm_valid_o ? mem_rdata_i : 32'h0;
    assign stall_if_o  = if_req_i & ~if_valid_o;
    assign stall_mem_o = dm_req_i & ~dm_valid_o;

endmodule
